player_link: RTL and testbench

- Serial transceiver between the local game FSM and the opponent board.
- Serializes the local {ready1, hit1, ship_cords_out} handshake word onto a single wire.
- Deserializes the opponent's word into {ready2, hit2, ship_cords_in}, which feed the game FSM directly.
- Sits between the game FSM and the PMOD/GPIO pins joining the two FPGAs.

---
 rtl/player_link.sv | 252 +++++++++++++++++++++++++
 tb/tb_player_link.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_link.sv
// player_link: serial link carrying the {ready, hit, cords} handshake word between the two boards.
// Define LINK_LOOPBACK_EN to feed tx back into the receiver for single-board bring-up.
module player_link #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned REFRESH_CYCLES = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready1,
  input  logic       hit1,
  input  logic [7:0] ship_cords_out,
  output logic       ready2,
  output logic       hit2,
  output logic [7:0] ship_cords_in,
  output logic       tx,
  input  logic       rx,
  output logic       link_up,
  output logic       frame_err
);
  localparam int unsigned WORD_W = 10;
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WORD_W - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [WORD_W-1:0] live_word;
  assign live_word = {ready1, hit1, ship_cords_out};

  state_t            tx_state, tx_state_nx;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_nx;
  logic [BIT_W-1:0]  tx_bit, tx_bit_nx;
  logic [WORD_W-1:0] tx_shift, tx_shift_nx, last_sent, last_sent_nx;
  logic [REF_W-1:0]  ref_cnt, ref_cnt_nx;
  logic              tx_nx, tx_cell_end;

  // Transmitter: frame on word change or refresh expiry; tx is computed one cycle ahead
  always_comb begin
    tx_state_nx  = tx_state;
    tx_cnt_nx    = tx_cnt;
    tx_bit_nx    = tx_bit;
    tx_shift_nx  = tx_shift;
    last_sent_nx = last_sent;
    ref_cnt_nx   = ref_cnt;
    tx_nx        = tx;
    tx_cell_end  = (tx_cnt == BIT_LAST);
    case (tx_state)
      S_IDLE: begin
        tx_nx = 1'b1;
        if ((live_word != last_sent) || (ref_cnt == REF_LAST)) begin
          tx_state_nx  = S_START;
          tx_shift_nx  = live_word;
          last_sent_nx = live_word;
          ref_cnt_nx   = '0;
          tx_cnt_nx    = '0;
          tx_nx        = 1'b0;
        end else begin
          ref_cnt_nx = ref_cnt + REF_W'(1);
        end
      end
      S_START: begin
        if (tx_cell_end) begin
          tx_state_nx = S_DATA;
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_nx       = tx_shift[0];
        end else tx_cnt_nx = tx_cnt + CNT_W'(1);
      end
      S_DATA: begin
        if (tx_cell_end) begin
          tx_cnt_nx = '0;
          if (tx_bit == DATA_LAST) begin
            tx_state_nx = S_PARITY;
            tx_nx       = ^last_sent;
          end else begin
            tx_bit_nx   = tx_bit + BIT_W'(1);
            tx_shift_nx = tx_shift >> 1;
            tx_nx       = tx_shift[1];
          end
        end else tx_cnt_nx = tx_cnt + CNT_W'(1);
      end
      S_PARITY: begin
        if (tx_cell_end) begin
          tx_state_nx = S_STOP;
          tx_cnt_nx   = '0;
          tx_nx       = 1'b1;
        end else tx_cnt_nx = tx_cnt + CNT_W'(1);
      end
      S_STOP: begin
        if (tx_cell_end) begin
          tx_state_nx = S_IDLE;
          tx_cnt_nx   = '0;
          tx_nx       = 1'b1;
        end else tx_cnt_nx = tx_cnt + CNT_W'(1);
      end
      default: begin
        tx_state_nx = S_IDLE;
        tx_nx       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      last_sent <= '0;
      ref_cnt   <= '0;
      tx        <= 1'b1;
    end else begin
      tx_state  <= tx_state_nx;
      tx_cnt    <= tx_cnt_nx;
      tx_bit    <= tx_bit_nx;
      tx_shift  <= tx_shift_nx;
      last_sent <= last_sent_nx;
      ref_cnt   <= ref_cnt_nx;
      tx        <= tx_nx;
    end
  end

  logic rx_src;
`ifdef LINK_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_src    = tx;
`else
  assign rx_src = rx;
`endif

  state_t            rx_state, rx_state_nx;
  logic              rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_nx;
  logic [BIT_W-1:0]  rx_bit, rx_bit_nx;
  logic [WORD_W-1:0] rx_shift, rx_shift_nx;
  logic              rx_par, rx_par_nx, rx_cell_end, frame_ok, frame_bad;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic              link_up_nx, ready2_nx, hit2_nx, frame_err_nx;
  logic [7:0]        cords_nx;

  // Receiver plus link supervision; outputs only move as a whole word on an accepted frame
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_par_nx   = rx_par;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    rx_cell_end = (rx_cnt == BIT_LAST);
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_nx = S_START;
          rx_cnt_nx   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx = '0;
          rx_bit_nx = '0;
          rx_state_nx = rx_s2 ? S_IDLE : S_DATA;
        end else rx_cnt_nx = rx_cnt + CNT_W'(1);
      end
      S_DATA: begin
        if (rx_cell_end) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s2, rx_shift[WORD_W-1:1]};
          if (rx_bit == DATA_LAST) rx_state_nx = S_PARITY;
          else rx_bit_nx = rx_bit + BIT_W'(1);
        end else rx_cnt_nx = rx_cnt + CNT_W'(1);
      end
      S_PARITY: begin
        if (rx_cell_end) begin
          rx_cnt_nx   = '0;
          rx_par_nx   = rx_s2;
          rx_state_nx = S_STOP;
        end else rx_cnt_nx = rx_cnt + CNT_W'(1);
      end
      S_STOP: begin
        if (rx_cell_end) begin
          rx_cnt_nx   = '0;
          rx_state_nx = S_IDLE;
          if (rx_s2 && (rx_par == ^rx_shift)) frame_ok = 1'b1;
          else frame_bad = 1'b1;
        end else rx_cnt_nx = rx_cnt + CNT_W'(1);
      end
      default: rx_state_nx = S_IDLE;
    endcase

    to_cnt_nx    = to_cnt;
    link_up_nx   = link_up;
    ready2_nx    = ready2;
    hit2_nx      = hit2;
    cords_nx     = ship_cords_in;
    frame_err_nx = frame_bad;
    if (frame_ok) begin
      to_cnt_nx  = '0;
      link_up_nx = 1'b1;
      {ready2_nx, hit2_nx, cords_nx} = rx_shift;
    end else if (to_cnt != TO_LAST) begin
      to_cnt_nx = to_cnt + TO_W'(1);
    end else begin
      link_up_nx = 1'b0;
      ready2_nx  = 1'b0;
      hit2_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      to_cnt        <= '0;
      link_up       <= 1'b0;
      ready2        <= 1'b0;
      hit2          <= 1'b0;
      ship_cords_in <= 8'h00;
      frame_err     <= 1'b0;
    end else begin
      rx_s1         <= rx_src;
      rx_s2         <= rx_s1;
      rx_prev       <= rx_s2;
      rx_state      <= rx_state_nx;
      rx_cnt        <= rx_cnt_nx;
      rx_bit        <= rx_bit_nx;
      rx_shift      <= rx_shift_nx;
      rx_par        <= rx_par_nx;
      to_cnt        <= to_cnt_nx;
      link_up       <= link_up_nx;
      ready2        <= ready2_nx;
      hit2          <= hit2_nx;
      ship_cords_in <= cords_nx;
      frame_err     <= frame_err_nx;
    end
  end

endmodule

// File: tb/tb_player_link.sv
// tb_player_link: directed bench for player_link with tx looped to rx through a breakable switch,
// a tx frame decoder and a word-level model of what the receiver outputs must show.
`timescale 1ns/1ps
module tb_player_link;
  localparam int unsigned C     = 16;
  localparam int unsigned R     = 1024;
  localparam int unsigned T     = 4096;
  localparam int unsigned FRAME = 13 * C;

  logic       clk = 1'b0;
  logic       rst, ready1, hit1, rx, loop, rx_drv;
  logic [7:0] ship_cords_out;
  logic       ready2, hit2, tx, link_up, frame_err;
  logic [7:0] ship_cords_in;

  assign rx = loop ? tx : rx_drv;

  player_link #(.CLKS_PER_BIT(C), .REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ready1(ready1), .hit1(hit1), .ship_cords_out(ship_cords_out),
    .ready2(ready2), .hit2(hit2), .ship_cords_in(ship_cords_in), .tx(tx), .rx(rx),
    .link_up(link_up), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          err_seen = 0;
  logic        fe_prev = 1'b0;
  logic        chk_en = 1'b0;
  logic [9:0]  exp_word = '0;
  logic        exp_link = 1'b0;
  logic [12:0] mon_seq_q[$];
  int unsigned mon_st_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Serial image of a word in line order: start, data LSB first, even parity, stop
  function automatic logic [12:0] build_frame(input logic [9:0] w);
    return {1'b1, ^w, w, 1'b0};
  endfunction

  // Output model: every cycle the outputs are meaningful they must equal the model word
  always @(negedge clk) begin
    if (chk_en)
      chk("rx_outputs", 32'({link_up, ready2, hit2, ship_cords_in}), 32'({exp_link, exp_word}));
    if (rst === 1'b1 && frame_err === 1'b1) begin
      err_seen <= err_seen + 1;
      chk("frame_err_one_cycle", 32'(fe_prev), 32'd0);
    end
    fe_prev <= frame_err;
  end

  // tx decoder: captures each frame cycle by cycle, checks every bit cell is exactly C stable cycles
  always begin : tx_mon
    logic [12:0] seq;
    int unsigned st;
    bit          aborted;
    bit          cell_ok;
    @(negedge clk);
    if (rst === 1'b1 && tx === 1'b0) begin
      st = cyc; aborted = 1'b0; cell_ok = 1'b1; seq = '0;
      for (int k = 0; k < int'(FRAME); k++) begin
        if (k != 0) @(negedge clk);
        if (rst !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (k % C == 0) seq[k / C] = tx;
        else if (tx !== seq[k / C]) cell_ok = 1'b0;
      end
      if (!aborted) begin
        chk("tx_cell_stable", 32'(cell_ok), 32'd1);
        mon_seq_q.push_back(seq);
        mon_st_q.push_back(st);
      end
    end
  end

  task automatic wait_frame(output logic [12:0] seq, output int unsigned st);
    int n = 0;
    while (mon_seq_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_frame_seen", 32'(mon_seq_q.size() != 0), 32'd1);
    if (mon_seq_q.size() != 0) begin
      seq = mon_seq_q.pop_front();
      st  = mon_st_q.pop_front();
    end else begin
      seq = '0;
      st  = 0;
    end
  endtask

  task automatic expect_frame(input logic [9:0] w, output logic [12:0] seq, output int unsigned st);
    wait_frame(seq, st);
    chk("tx_frame_content", 32'(seq), 32'(build_frame(w)));
  endtask

  task automatic wait_tx_low(input string name);
    int n = 0;
    while (tx !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(tx === 1'b0), 32'd1);
  endtask

  task automatic send_rx(input logic [9:0] w, input logic flip, input logic stop);
    logic [12:0] f;
    f = {stop, (^w) ^ flip, w, 1'b0};
    for (int i = 0; i < 13; i++) begin
      rx_drv = f[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic accept_model(input logic [9:0] w);
    repeat (2) @(negedge clk);
    exp_word = w;
    exp_link = 1'b1;
    chk_en   = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    logic [12:0] seq;
    int unsigned st1, st2, st_f, st_a, st_b;
    loop = 1'b1; rx_drv = 1'b1; rst = 1'b0;
    ready1 = 1'b1; hit1 = 1'b0; ship_cords_out = 8'h23;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_ready2", 32'(ready2), 32'd0);
    chk("rst_hit2", 32'(hit2), 32'd0);
    chk("rst_cords_in", 32'(ship_cords_in), 32'h00);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;

    // First frame, with the local word changed while it is on the wire
    wait_tx_low("first_frame_start");
    repeat (50) @(negedge clk);
    ship_cords_out = 8'h45;
    repeat (100) @(negedge clk);
    chk_en = 1'b0;
    expect_frame(10'h223, seq, st1);
    chk("frame1_literal", 32'(seq), 32'(13'b1010001000110));
    accept_model(10'h223);
    chk("frame1_ready2", 32'(ready2), 32'd1);
    chk("frame1_hit2", 32'(hit2), 32'd0);
    chk("frame1_cords_in", 32'(ship_cords_in), 32'h23);
    chk("frame1_link_up", 32'(link_up), 32'd1);
    repeat (150) @(negedge clk);
    chk_en = 1'b0;
    expect_frame(10'h245, seq, st2);
    chk("back_to_back_gap", 32'(st2 - st1), 32'(FRAME + 1));
    accept_model(10'h245);

    // Injected bad frames with the loop broken: outputs must hold
    loop = 1'b0; rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    send_rx(10'h3C6, 1'b1, 1'b1);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("parity_err_count", 32'(err_seen), 32'd1);
    chk("parity_err_cords_hold", 32'(ship_cords_in), 32'h45);
    send_rx(10'h155, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("stop_err_count", 32'(err_seen), 32'd2);
    chk_en = 1'b0;
    send_rx(10'h35A, 1'b0, 1'b1);
    accept_model(10'h35A);
    chk("inject_hit2", 32'(hit2), 32'd1);
    chk("inject_cords_in", 32'(ship_cords_in), 32'h5A);

    // Reconnect on an idle line, then refresh frames every R idle cycles
    mon_seq_q.delete(); mon_st_q.delete();
    expect_frame(10'h245, seq, st_f);
    loop = 1'b1;
    chk_en = 1'b0;
    expect_frame(10'h245, seq, st_a);
    chk("refresh_period_1", 32'(st_a - st_f), 32'(FRAME + R));
    accept_model(10'h245);
    expect_frame(10'h245, seq, st_b);
    chk("refresh_period_2", 32'(st_b - st_a), 32'(FRAME + R));

    // Link timeout with the loop broken
    loop = 1'b0; rx_drv = 1'b1;
    repeat (T - 200) @(negedge clk);
    chk_en = 1'b0;
    repeat (400) @(negedge clk);
    exp_link = 1'b0;
    exp_word[9:8] = 2'b00;
    chk_en = 1'b1;
    chk("timeout_link_up", 32'(link_up), 32'd0);
    chk("timeout_ready2", 32'(ready2), 32'd0);
    chk("timeout_hit2", 32'(hit2), 32'd0);
    chk("timeout_cords_hold", 32'(ship_cords_in), 32'h45);

    // Short low glitch: no frame, no error
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_no_err", 32'(err_seen), 32'd2);
    chk_en = 1'b0;
    send_rx(10'h3C3, 1'b0, 1'b1);
    accept_model(10'h3C3);
    chk("relink_link_up", 32'(link_up), 32'd1);

    // Reset in the middle of the data bits, then a complete fresh frame
    mon_seq_q.delete(); mon_st_q.delete();
    expect_frame(10'h245, seq, st1);
    ready1 = 1'b1; hit1 = 1'b1; ship_cords_out = 8'h77;
    wait_tx_low("rst_frame_start");
    repeat (3 * C) @(negedge clk);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_async_tx", 32'(tx), 32'd1);
    mon_seq_q.delete(); mon_st_q.delete();
    @(negedge clk);
    chk("rst_mid_link_up", 32'(link_up), 32'd0);
    chk("rst_mid_cords_in", 32'(ship_cords_in), 32'h00);
    loop = 1'b1;
    exp_word = '0; exp_link = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_frame(10'h377, seq, st2);
    accept_model(10'h377);
    chk("fresh_cords_in", 32'(ship_cords_in), 32'h77);
    chk("fresh_hit2", 32'(hit2), 32'd1);
    repeat (50) @(negedge clk);
    chk("final_err_count", 32'(err_seen), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
